// File: rtl/wave_analyzer.sv
// wave_analyzer: measures level, high-run length and period of a two-level square wave
// Ports:
//   clk, rstn (sync, active-low)     clock and reset
//   sample_en                        accept wave on this edge; otherwise state holds
//   wave[WIDTH-1:0]                  sample stream (one level is the complement of the other)
//   volume/duty_cycle/period         last measurement, updated with meas_valid
//   meas_valid, err, timeout         single-cycle pulses; locked is a level
// Macro WAVE_ANALYZER_STABLE_EN: publish a measurement only when it repeats the previous candidate.
module wave_analyzer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] wave,
  output logic [WIDTH-1:0] volume,
  output logic [WIDTH-1:0] duty_cycle,
  output logic [WIDTH-1:0] period,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);
  typedef enum logic [1:0] {SEEK, ACQ, LOCK} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] prev_q, cnt_q, cnt_d, cnt_inc, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] vol_q, duty_q, per_q, per_sat;
  logic [WIDTH:0] sum;
  logic pv_q, nrun_q, nrun_d, mv_q, mv_d, err_q, err_d, to_q, to_d;
  logic trans, cmpl, cand, cand_ok;
  assign trans   = pv_q && (wave != prev_q);
  assign cmpl    = (wave == ~prev_q);
  assign cnt_inc = cnt_q + 1'b1;
  // a clean transition into the MSB-0 level closes a full high+low cycle
  assign cand    = (state_q == LOCK) && trans && cmpl && !wave[WIDTH-1];
  assign sum     = {1'b0, hi_q} + {1'b0, lo_d};
  assign per_sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`ifdef WAVE_ANALYZER_STABLE_EN
  logic [WIDTH-1:0] c_hi_q, c_lo_q, c_vol_q;
  logic cv_q;
  assign cand_ok = cand && cv_q && (c_hi_q == hi_q) && (c_lo_q == lo_d) && (c_vol_q == wave);
`else
  assign cand_ok = cand;
`endif
  assign mv_d = sample_en && cand_ok;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    nrun_d  = nrun_q;
    err_d   = 1'b0;
    to_d    = 1'b0;
    if (sample_en) begin
      if (trans && !cmpl) begin
        err_d   = 1'b1;
        state_d = ACQ;
        cnt_d   = WIDTH'(1);
        hi_d    = '0;
        lo_d    = '0;
        nrun_d  = 1'b0;
      end else if (trans) begin
        cnt_d = WIDTH'(1);
        if (state_q == SEEK) state_d = ACQ;
        else begin
          if (prev_q[WIDTH-1]) lo_d = cnt_q;
          else hi_d = cnt_q;
          nrun_d = 1'b1;
          if (state_q == ACQ && nrun_q) state_d = LOCK;
        end
      end else if (state_q != SEEK) begin
        cnt_d = cnt_inc;
        if (&cnt_inc) begin
          to_d    = 1'b1;
          state_d = SEEK;
          cnt_d   = '0;
          nrun_d  = 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= SEEK;
      prev_q  <= '0;
      pv_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      nrun_q  <= 1'b0;
      vol_q   <= '0;
      duty_q  <= '0;
      per_q   <= '0;
      mv_q    <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
`ifdef WAVE_ANALYZER_STABLE_EN
      c_hi_q  <= '0;
      c_lo_q  <= '0;
      c_vol_q <= '0;
      cv_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      nrun_q  <= nrun_d;
      mv_q    <= mv_d;
      err_q   <= err_d;
      to_q    <= to_d;
      if (sample_en) begin
        prev_q <= wave;
        pv_q   <= 1'b1;
      end
      if (mv_d) begin
        vol_q  <= wave;
        duty_q <= hi_q;
        per_q  <= per_sat;
      end
`ifdef WAVE_ANALYZER_STABLE_EN
      // candidate memory is forgotten whenever not locked, so the first one after LOCK is only stored
      if (sample_en && cand) begin
        c_hi_q  <= hi_q;
        c_lo_q  <= lo_d;
        c_vol_q <= wave;
        cv_q    <= 1'b1;
      end else if (state_q != LOCK) cv_q <= 1'b0;
`endif
    end
  end
  assign volume     = vol_q;
  assign duty_cycle = duty_q;
  assign period     = per_q;
  assign meas_valid = mv_q;
  assign locked     = (state_q == LOCK);
  assign err        = err_q;
  assign timeout    = to_q;
endmodule

// File: tb/tb_wave_analyzer.sv
// tb_wave_analyzer: directed self-checking bench for wave_analyzer
module tb_wave_analyzer;
  localparam logic [15:0] H = 16'h1000, L = 16'hEFFF, X = 16'h2000, V = 16'h0F0F, VN = 16'hF0F0;
  logic clk = 1'b0, rstn = 1'b0, en = 1'b0, s_en = 1'b0;
  logic [15:0] wave = '0;
  logic [7:0] s_wave = '0;
  logic [15:0] volume, duty_cycle, period;
  logic meas_valid, locked, err, timeout;
  logic [7:0] s_vol, s_duty, s_per;
  logic s_mv, s_lk, s_err, s_to;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  wave_analyzer u_dut (
    .clk(clk), .rstn(rstn), .sample_en(en), .wave(wave),
    .volume(volume), .duty_cycle(duty_cycle), .period(period),
    .meas_valid(meas_valid), .locked(locked), .err(err), .timeout(timeout)
  );
  wave_analyzer #(.WIDTH(8)) u_sat (
    .clk(clk), .rstn(rstn), .sample_en(s_en), .wave(s_wave),
    .volume(s_vol), .duty_cycle(s_duty), .period(s_per),
    .meas_valid(s_mv), .locked(s_lk), .err(s_err), .timeout(s_to)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic outs(input string tag, input logic mv, input logic lk, input logic e, input logic t,
                      input logic [15:0] v, input logic [15:0] d, input logic [15:0] p);
    chk({tag, ".meas_valid"}, 32'(meas_valid), 32'(mv));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".timeout"}, 32'(timeout), 32'(t));
    chk({tag, ".volume"}, 32'(volume), 32'(v));
    chk({tag, ".duty_cycle"}, 32'(duty_cycle), 32'(d));
    chk({tag, ".period"}, 32'(period), 32'(p));
  endtask
  task automatic step(input logic [15:0] w);
    wave = w;
    en = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [15:0] w, input int n);
    repeat (n) step(w);
  endtask
  task automatic idle();
    en = 1'b0;
    wave = 16'h5555;
    @(posedge clk);
    #1;
  endtask
  task automatic sstep(input logic [7:0] w, input int n);
    repeat (n) begin
      s_wave = w;
      s_en = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    en = 1'b0;
    s_en = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    outs("reset", 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    rstn = 1'b1;
    // basic lock and first measurement: 3 high / 7 low
    run(H, 3); run(L, 7); run(H, 3);
    chk("acq_unlocked", 32'(locked), 32'd0);
    step(L);
    chk("lock_at_13", 32'(locked), 32'd1);
    run(L, 6);
    chk("no_mv_at_19", 32'(meas_valid), 32'd0);
    step(H);
    outs("meas_at_20", 1, 1, 0, 0, H, 16'd3, 16'd10);
    step(H);
    chk("mv_single_pulse", 32'(meas_valid), 32'd0);
    step(H); run(L, 7);
    // non-complement level change while locked
    step(X);
    outs("err_inject", 0, 0, 1, 0, H, 16'd3, 16'd10);
    run(X, 6);
    chk("err_single_pulse", 32'(err), 32'd0);
    step(H);
    chk("err_back_to_high", 32'(err), 32'd1);
    run(H, 2); run(L, 7); step(H);
    chk("relock", 32'(locked), 32'd1);
    chk("relock_no_mv", 32'(meas_valid), 32'd0);
    run(H, 2); run(L, 7); step(H);
    outs("relock_meas", 1, 1, 0, 0, H, 16'd3, 16'd10);
    // reset mid-run with sample_en high
    step(H);
    rstn = 1'b0;
    step(H);
    outs("reset_mid_run", 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    rstn = 1'b1;
    run(H, 3); run(L, 7); run(H, 3); run(L, 7);
    chk("restart_no_mv_19", 32'(meas_valid), 32'd0);
    step(H);
    outs("restart_meas_20", 1, 1, 0, 0, H, 16'd3, 16'd10);
    // same stream with sample_en low every other cycle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step((i % 10) < 3 ? H : L);
      idle();
    end
    chk("gated_no_mv_19", 32'(meas_valid), 32'd0);
    chk("gated_locked", 32'(locked), 32'd1);
    step(H);
    outs("gated_meas_20", 1, 1, 0, 0, H, 16'd3, 16'd10);
    idle();
    outs("gated_hold", 0, 1, 0, 0, H, 16'd3, 16'd10);
    // second pattern: 5 high / 4 low at another level
    do_reset();
    run(V, 5); run(VN, 4); run(V, 5); run(VN, 4);
    chk("p2_no_mv", 32'(meas_valid), 32'd0);
    step(V);
    outs("p2_meas", 1, 1, 0, 0, V, 16'd5, 16'd9);
    // constant input until the run counter saturates
    run(V, 65533);
    chk("timeout_not_yet", 32'(timeout), 32'd0);
    step(V);
    outs("timeout", 0, 0, 0, 1, V, 16'd5, 16'd9);
    step(V);
    outs("after_timeout", 0, 0, 0, 0, V, 16'd5, 16'd9);
    step(VN);
    chk("seek_trans_no_mv", 32'(meas_valid), 32'd0);
    chk("seek_trans_unlocked", 32'(locked), 32'd0);
    // period saturation on the 8-bit instance: 200 high + 200 low
    do_reset();
    sstep(8'hEF, 1); sstep(8'h10, 200); sstep(8'hEF, 200); sstep(8'h10, 200);
    chk("sat_locked", 32'(s_lk), 32'd1);
    sstep(8'hEF, 200);
    chk("sat_no_mv", 32'(s_mv), 32'd0);
    sstep(8'h10, 1);
    chk("sat_mv", 32'(s_mv), 32'd1);
    chk("sat_period", 32'(s_per), 32'hFF);
    chk("sat_duty", 32'(s_duty), 32'd200);
    chk("sat_volume", 32'(s_vol), 32'h10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
